// File: rtl/spi_txn_arbiter_if.sv
// spi_txn_arbiter_if: requester and SPI-engine signals shared by the arbiter and its environment
interface spi_txn_arbiter_if #(parameter int N_REQ = 4);
  logic [N_REQ-1:0] req;
  logic [8*N_REQ-1:0] req_data;
  logic [N_REQ-1:0] gnt;
  logic [N_REQ-1:0] rsp_valid;
  logic [7:0] rsp_data;
  logic rsp_err;
  logic master_start;
  logic [7:0] master_data_in;
  logic master_busy;
  logic [7:0] master_data_out;
  logic arb_busy;
  modport master (
    input req, req_data, master_busy, master_data_out,
    output gnt, rsp_valid, rsp_data, rsp_err, master_start, master_data_in, arb_busy
  );
  modport slave (
    output req, req_data, master_busy, master_data_out,
    input gnt, rsp_valid, rsp_data, rsp_err, master_start, master_data_in, arb_busy
  );
endinterface

// File: rtl/spi_txn_arbiter.sv
// spi_txn_arbiter: round-robin sharing of one SPI byte engine among N_REQ requesters with watchdogs
module spi_txn_arbiter #(
  parameter int N_REQ = 4,
  parameter int ACK_TIMEOUT = 16,
  parameter int XFER_TIMEOUT = 1024
) (
  input logic clk,
  input logic rst,
  spi_txn_arbiter_if.master bus
);
  localparam int IW = N_REQ > 1 ? $clog2(N_REQ) : 1;
  localparam int AW = ACK_TIMEOUT > 1 ? $clog2(ACK_TIMEOUT) : 1;
  localparam int XW = XFER_TIMEOUT > 1 ? $clog2(XFER_TIMEOUT) : 1;
  localparam int CW = AW > XW ? AW : XW;
  typedef enum logic [2:0] {IDLE, START, WAIT_ACK, WAIT_DONE, RESP} state_t;
  state_t state_q, state_d;
  logic [IW-1:0] w_q, w_d, ptr_q, ptr_d, win, idx;
  logic found;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [7:0] byte_q, byte_d, data_q, data_d;
  logic err_q, err_d;
  logic [N_REQ-1:0] w_oh;
  always_comb begin
    win = '0;
    idx = '0;
    found = 1'b0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = IW'((int'(ptr_q) + k) % N_REQ);
      if (!found && bus.req[idx]) begin
        win = idx;
        found = 1'b1;
      end
    end
  end
  always_comb begin
    state_d = state_q;
    w_d = w_q;
    ptr_d = ptr_q;
    cnt_d = cnt_q;
    byte_d = byte_q;
    data_d = data_q;
    err_d = err_q;
    unique case (state_q)
      IDLE: if (found) begin
        state_d = START;
        w_d = win;
        byte_d = bus.req_data[8*win +: 8];
      end
      START: begin
        state_d = WAIT_ACK;
        cnt_d = '0;
      end
      WAIT_ACK: if (bus.master_busy) begin
        state_d = WAIT_DONE;
        cnt_d = '0;
      end else if (cnt_q == CW'(ACK_TIMEOUT - 1)) begin
        state_d = RESP;
        err_d = 1'b1;
        data_d = '0;
      end else cnt_d = cnt_q + 1'b1;
      WAIT_DONE: if (!bus.master_busy) begin
        state_d = RESP;
        err_d = 1'b0;
        data_d = bus.master_data_out;
      end else if (cnt_q == CW'(XFER_TIMEOUT - 1)) begin
        state_d = RESP;
        err_d = 1'b1;
        data_d = '0;
      end else cnt_d = cnt_q + 1'b1;
      RESP: begin
        state_d = IDLE;
        ptr_d = (w_q == IW'(N_REQ - 1)) ? '0 : w_q + 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      w_q <= '0;
      ptr_q <= '0;
      cnt_q <= '0;
      byte_q <= '0;
      data_q <= '0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      w_q <= w_d;
      ptr_q <= ptr_d;
      cnt_q <= cnt_d;
      byte_q <= byte_d;
      data_q <= data_d;
      err_q <= err_d;
    end
  end
  assign w_oh = N_REQ'(1) << w_q;
  assign bus.gnt = (state_q == IDLE) ? '0 : w_oh;
  assign bus.rsp_valid = (state_q == RESP) ? w_oh : '0;
  assign bus.rsp_data = (state_q == RESP) ? data_q : '0;
  assign bus.rsp_err = (state_q == RESP) ? err_q : 1'b0;
  assign bus.master_start = (state_q == START);
  assign bus.master_data_in = byte_q;
  assign bus.arb_busy = (state_q != IDLE);
endmodule

// File: tb/tb_spi_txn_arbiter.sv
// tb_spi_txn_arbiter: directed scoreboard bench with a behavioural SPI engine model
module tb_spi_txn_arbiter;
  typedef struct packed {logic [3:0] oh; logic [7:0] d; logic e;} txn_t;
  logic clk, rst;
  int n_assert = 0, n_fail = 0;
  txn_t sq[$], rq[$], se, re;
  logic [7:0] key, cap;
  int busy_len, rem;
  bit no_ack, stuck;
  int c;
  spi_txn_arbiter_if #(.N_REQ(4)) b();
  spi_txn_arbiter #(.N_REQ(4), .ACK_TIMEOUT(16), .XFER_TIMEOUT(64)) dut (.clk(clk), .rst(rst), .bus(b));
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) begin
    if (rst) begin
      rem <= 0;
      cap <= '0;
    end else if (b.master_start && !no_ack) begin
      rem <= busy_len;
      cap <= b.master_data_in ^ key;
    end else if (rem != 0) rem <= rem - 1;
  end
  assign b.master_busy = stuck | (rem != 0);
  assign b.master_data_out = cap;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic exp_txn(input int i, input logic [7:0] d, input logic [7:0] r, input logic e);
    sq.push_back('{oh: 4'(1 << i), d: d, e: 1'b0});
    rq.push_back('{oh: 4'(1 << i), d: r, e: e});
  endtask
  task automatic wait_rsp(output int cyc);
    cyc = 0;
    do begin step(); cyc++; end while (b.rsp_valid == '0 && cyc < 2000);
    chk("rsp_arrived", 32'(b.rsp_valid != '0), 1);
  endtask
  task automatic wait_start();
    int cyc = 0;
    do begin step(); cyc++; end while (!b.master_start && cyc < 2000);
    chk("start_arrived", 32'(b.master_start), 1);
  endtask
  always @(negedge clk) begin
    if (!rst) begin
      if (b.master_start) begin
        if (sq.size() == 0) chk("unexpected_start", 32'(b.master_start), 0);
        else begin
          se = sq.pop_front();
          chk("start_gnt", 32'(b.gnt), 32'(se.oh));
          chk("start_data_in", 32'(b.master_data_in), 32'(se.d));
        end
      end
      if (b.rsp_valid != '0) begin
        if (rq.size() == 0) chk("unexpected_rsp", 32'(b.rsp_valid), 0);
        else begin
          re = rq.pop_front();
          chk("rsp_valid", 32'(b.rsp_valid), 32'(re.oh));
          chk("rsp_gnt_held", 32'(b.gnt), 32'(re.oh));
          chk("rsp_data", 32'(b.rsp_data), 32'(re.d));
          chk("rsp_err", 32'(b.rsp_err), 32'(re.e));
        end
      end else chk("rsp_data_idle", 32'(b.rsp_data), 0);
    end
  end
  initial begin
    rst = 1'b1; b.req = '0; b.req_data = '0;
    key = '0; busy_len = 3; no_ack = 0; stuck = 0;
    repeat (3) step();
    chk("reset_gnt", 32'(b.gnt), 0);
    chk("reset_rsp_valid", 32'(b.rsp_valid), 0);
    chk("reset_start", 32'(b.master_start), 0);
    chk("reset_data_in", 32'(b.master_data_in), 0);
    chk("reset_arb_busy", 32'(b.arb_busy), 0);
    chk("reset_rsp_err", 32'(b.rsp_err), 0);
    rst = 1'b0;
    key = 8'h5A;
    b.req_data = 32'h13121110;
    for (int k = 0; k < 5; k++) exp_txn(k % 4, 8'(8'h10 + k % 4), 8'((8'h10 + k % 4) ^ 8'h5A), 1'b0);
    b.req = 4'hF;
    for (int k = 0; k < 5; k++) begin
      wait_rsp(c);
      if (k == 4) b.req = '0;
    end
    step();
    chk("rr_idle", 32'(b.arb_busy), 0);
    key = 8'hA5 ^ 8'h3C; busy_len = 20;
    b.req_data = 32'h0000A500;
    exp_txn(1, 8'hA5, 8'h3C, 1'b0);
    b.req = 4'b0010;
    step();
    chk("single_start_latency", 32'(b.master_start), 1);
    chk("single_gnt", 32'(b.gnt), 32'b0010);
    chk("single_data_in", 32'(b.master_data_in), 32'hA5);
    wait_rsp(c);
    chk("single_rsp_latency", c, 22);
    b.req = '0;
    step();
    chk("single_data_in_held", 32'(b.master_data_in), 32'hA5);
    chk("single_idle", 32'(b.arb_busy), 0);
    key = 8'h11; busy_len = 2;
    b.req_data = 32'hD3C200C0;
    exp_txn(3, 8'hD3, 8'hD3 ^ 8'h11, 1'b0);
    b.req = 4'b1000;
    wait_rsp(c);
    exp_txn(0, 8'hC0, 8'hC0 ^ 8'h11, 1'b0);
    exp_txn(2, 8'hC2, 8'hC2 ^ 8'h11, 1'b0);
    b.req = 4'b0101;
    wait_rsp(c);
    b.req = 4'b0100;
    wait_rsp(c);
    b.req = '0;
    no_ack = 1;
    b.req_data = 32'h0000E1E0;
    exp_txn(0, 8'hE0, 8'h00, 1'b1);
    b.req = 4'b0001;
    wait_start();
    wait_rsp(c);
    chk("ack_timeout_latency", c, 17);
    no_ack = 0; busy_len = 4; key = 8'h22;
    exp_txn(1, 8'hE1, 8'hE1 ^ 8'h22, 1'b0);
    exp_txn(0, 8'hE0, 8'hE0 ^ 8'h22, 1'b0);
    b.req = 4'b0011;
    step();
    chk("ack_timeout_idle", 32'(b.arb_busy), 0);
    wait_rsp(c);
    wait_rsp(c);
    b.req = '0;
    stuck = 1; key = 8'h33;
    b.req_data = 32'hF3F20000;
    exp_txn(2, 8'hF2, 8'h00, 1'b1);
    b.req = 4'b0100;
    wait_start();
    wait_rsp(c);
    chk("xfer_timeout_latency", c, 66);
    stuck = 0; busy_len = 5;
    b.req = '0;
    exp_txn(3, 8'hF3, 8'hF3 ^ 8'h33, 1'b0);
    step();
    b.req = 4'b1000;
    wait_rsp(c);
    b.req = '0;
    busy_len = 10; key = 8'h44;
    b.req_data = 32'h00828100;
    exp_txn(1, 8'h81, 8'h81 ^ 8'h44, 1'b0);
    b.req = 4'b0010;
    wait_start();
    step();
    b.req = 4'b0110;
    step();
    step();
    b.req = 4'b0010;
    wait_rsp(c);
    b.req = '0;
    repeat (6) step();
    chk("withdraw_idle", 32'(b.arb_busy), 0);
    busy_len = 30;
    b.req_data = 32'h00000090;
    exp_txn(0, 8'h90, 8'h90 ^ 8'h44, 1'b0);
    b.req = 4'b0001;
    wait_start();
    repeat (5) step();
    chk("pre_reset_busy", 32'(b.arb_busy), 1);
    rst = 1'b1;
    b.req = 4'b1010;
    b.req_data = 32'hA300A100;
    step();
    chk("midreset_gnt", 32'(b.gnt), 0);
    chk("midreset_rsp_valid", 32'(b.rsp_valid), 0);
    chk("midreset_start", 32'(b.master_start), 0);
    chk("midreset_data_in", 32'(b.master_data_in), 0);
    chk("midreset_arb_busy", 32'(b.arb_busy), 0);
    sq.delete();
    rq.delete();
    rst = 1'b0; busy_len = 3;
    exp_txn(1, 8'hA1, 8'hA1 ^ 8'h44, 1'b0);
    step();
    chk("post_reset_start", 32'(b.master_start), 1);
    chk("post_reset_ptr_gnt", 32'(b.gnt), 32'b0010);
    wait_rsp(c);
    exp_txn(3, 8'hA3, 8'hA3 ^ 8'h44, 1'b0);
    b.req = 4'b1000;
    wait_rsp(c);
    b.req = '0;
    repeat (3) step();
    chk("start_queue_drained", sq.size(), 0);
    chk("rsp_queue_drained", rq.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
